spi_reg_slave: RTL and testbench

//  Parametrised SPI register-access slave, successor to the write-only 24-bit frame decoder.

---
 rtl/spi_slave_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_reg_slave.sv | 214 +++++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI register slave: mode numbers, FSM states, R/W bit encoding.
package spi_slave_pkg;

  localparam int MODE0 = 0;
  localparam int MODE1 = 1;
  localparam int MODE2 = 2;
  localparam int MODE3 = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RDATA,
    DONE
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for a bundle of asynchronous pins, with rise/fall detect on bit 0.
module spi_sync_edge #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         rise_o,
  output logic         fall_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL[0];
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q[0];
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q[0] & ~prev_q;
  assign fall_o = ~sync_q[0] & prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI register-access slave: oversampled pins, all four SPI modes, write and read frames.
// Define SPI_STREAM_EN to keep transferring auto-incremented words while SEN stays low.
module spi_reg_slave
  import spi_slave_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int PAD_W    = 3,
  parameter int SPI_MODE = MODE0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sclk_i,
  input  logic              sen_i,
  input  logic              sdi_i,
  output logic              sdo_o,
  output logic              sdo_oe_o,
  output logic              wr_valid_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              rd_req_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              frame_err_o
);

  localparam int   FRAME_W = 1 + PAD_W + ADDR_W + DATA_W;
  localparam int   HDR_W   = FRAME_W - DATA_W;
  localparam int   CNT_W   = $clog2(FRAME_W + 1);
  localparam logic CPOL    = ((SPI_MODE >> 1) & 1) != 0;
  localparam logic CPHA    = (SPI_MODE & 1) != 0;

  logic [2:0] pins_s;
  logic       sclk_rise, sclk_fall;
  logic       sen_s, sdi_s;
  logic       lead_e, trail_e, sample_e, shift_e;

  spi_sync_edge #(
    .W       (3),
    .RST_VAL ({1'b0, 1'b1, CPOL})
  ) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    ({sdi_i, sen_i, sclk_i}),
    .q_o    (pins_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  assign sen_s    = pins_s[1];
  assign sdi_s    = pins_s[2];
  assign lead_e   = CPOL ? sclk_fall : sclk_rise;
  assign trail_e  = CPOL ? sclk_rise : sclk_fall;
  assign sample_e = CPHA ? trail_e : lead_e;
  assign shift_e  = CPHA ? lead_e : trail_e;

  state_t            state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [ADDR_W-1:0] addr_sh_q, cur_addr_q, wr_addr_q, rd_addr_q;
  logic [DATA_W-1:0] data_sh_q, wr_data_q, out_q;
  logic              rw_q, first_q, word_seen_q, rd_pend_q;
  logic              sdo_oe_q, wr_valid_q, rd_req_q, frame_err_q;

  logic [ADDR_W-1:0] addr_next, addr_inc;
  logic [DATA_W-1:0] data_next;
  logic              hdr_last, word_last, abort_err;

  assign addr_next = ADDR_W'({addr_sh_q, sdi_s});
  assign data_next = DATA_W'({data_sh_q, sdi_s});
  assign addr_inc  = cur_addr_q + 1'b1;
  assign hdr_last  = bit_cnt_q == CNT_W'(HDR_W - 1);
  assign word_last = bit_cnt_q == CNT_W'(DATA_W - 1);
  // Releasing SEN exactly on a word boundary after at least one word is a clean end.
  assign abort_err = !(bit_cnt_q == '0 && word_seen_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      addr_sh_q   <= '0;
      cur_addr_q  <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      data_sh_q   <= '0;
      wr_data_q   <= '0;
      out_q       <= '0;
      rw_q        <= RW_WRITE;
      first_q     <= 1'b0;
      word_seen_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      sdo_oe_q    <= 1'b0;
      wr_valid_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_valid_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      frame_err_q <= 1'b0;
      rd_pend_q   <= rd_req_q;

      case (state_q)
        IDLE: begin
          sdo_oe_q <= 1'b0;
          if (!sen_s) begin
            state_q     <= ADDR;
            bit_cnt_q   <= '0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            rw_q        <= RW_WRITE;
            word_seen_q <= 1'b0;
          end
        end

        ADDR: begin
          if (sen_s) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
          end else if (sample_e) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            addr_sh_q <= addr_next;
            if (bit_cnt_q == '0) rw_q <= sdi_s;
            if (hdr_last) begin
              bit_cnt_q  <= '0;
              cur_addr_q <= addr_next;
              if (rw_q == RW_READ) begin
                rd_req_q  <= 1'b1;
                rd_addr_q <= addr_next;
                out_q     <= '0;
                first_q   <= 1'b1;
                sdo_oe_q  <= 1'b1;
                state_q   <= RDATA;
              end else begin
                state_q <= WDATA;
              end
            end
          end
        end

        WDATA: begin
          if (sample_e && word_last) begin
            wr_valid_q  <= 1'b1;
            wr_addr_q   <= cur_addr_q;
            wr_data_q   <= data_next;
            bit_cnt_q   <= '0;
            word_seen_q <= 1'b1;
`ifdef SPI_STREAM_EN
            cur_addr_q  <= addr_inc;
            state_q     <= sen_s ? IDLE : WDATA;
`else
            state_q     <= sen_s ? IDLE : DONE;
`endif
          end else if (sen_s) begin
            state_q     <= IDLE;
            frame_err_q <= abort_err;
          end else if (sample_e) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            data_sh_q <= data_next;
          end
        end

        RDATA: begin
          if (sample_e && word_last) begin
            bit_cnt_q   <= '0;
            word_seen_q <= 1'b1;
`ifdef SPI_STREAM_EN
            if (sen_s) begin
              state_q  <= IDLE;
              sdo_oe_q <= 1'b0;
            end else begin
              cur_addr_q <= addr_inc;
              rd_addr_q  <= addr_inc;
              rd_req_q   <= 1'b1;
              first_q    <= 1'b1;
            end
`else
            state_q  <= sen_s ? IDLE : DONE;
            sdo_oe_q <= 1'b0;
`endif
          end else if (sen_s) begin
            state_q     <= IDLE;
            sdo_oe_q    <= 1'b0;
            frame_err_q <= abort_err;
          end else begin
            if (sample_e) bit_cnt_q <= bit_cnt_q + 1'b1;
            // The first shift edge of a word keeps the freshly loaded MSB on the line.
            if (shift_e) begin
              if (first_q) first_q <= 1'b0;
              else out_q <= {out_q[DATA_W-2:0], 1'b0};
            end
          end
        end

        DONE: begin
          sdo_oe_q <= 1'b0;
          if (sen_s) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase

      if (rd_pend_q) out_q <= rd_data_i;
    end
  end

  assign sdo_oe_o    = sdo_oe_q & ~sen_s;
  assign sdo_o       = sdo_oe_o & out_q[DATA_W-1];
  assign wr_valid_o  = wr_valid_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign rd_req_o    = rd_req_q;
  assign rd_addr_o   = rd_addr_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: one mode-0 and one mode-3 instance driven by a bit-banged master.
module tb_spi_reg_slave;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        sdi = 1'b0;
  logic        sen0 = 1'b1;
  logic        sen3 = 1'b1;
  logic [7:0]  rd_data0 = 8'h00;
  logic [7:0]  rd_data3 = 8'h00;

  logic        sdo0, sdo_oe0, wr_valid0, rd_req0, frame_err0;
  logic [11:0] wr_addr0, rd_addr0;
  logic [7:0]  wr_data0;
  logic        sdo3, sdo_oe3, wr_valid3, rd_req3, frame_err3;
  logic [11:0] wr_addr3, rd_addr3;
  logic [7:0]  wr_data3;

  int checks = 0;
  int failures = 0;

  int wr_cnt0 = 0, rd_cnt0 = 0, ferr_cnt0 = 0, oe_cnt0 = 0, wr_cnt3 = 0;
  logic [11:0] wlog_addr [16];
  logic [7:0]  wlog_data [16];

  spi_reg_slave #(.SPI_MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .sen_i(sen0), .sdi_i(sdi),
    .sdo_o(sdo0), .sdo_oe_o(sdo_oe0), .wr_valid_o(wr_valid0), .wr_addr_o(wr_addr0),
    .wr_data_o(wr_data0), .rd_req_o(rd_req0), .rd_addr_o(rd_addr0),
    .rd_data_i(rd_data0), .frame_err_o(frame_err0)
  );

  spi_reg_slave #(.SPI_MODE(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .sen_i(sen3), .sdi_i(sdi),
    .sdo_o(sdo3), .sdo_oe_o(sdo_oe3), .wr_valid_o(wr_valid3), .wr_addr_o(wr_addr3),
    .wr_data_o(wr_data3), .rd_req_o(rd_req3), .rd_addr_o(rd_addr3),
    .rd_data_i(rd_data3), .frame_err_o(frame_err3)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid0) begin
      wlog_addr[wr_cnt0 % 16] = wr_addr0;
      wlog_data[wr_cnt0 % 16] = wr_data0;
      wr_cnt0++;
    end
    if (rd_req0) rd_cnt0++;
    if (frame_err0) ferr_cnt0++;
    if (sdo_oe0) oe_cnt0++;
    if (wr_valid3) wr_cnt3++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // rel: 0 keep SEN low, 1 release after the frame, 2 release with the last sample edge.
  task automatic spi_frame(input bit sel3, input logic [31:0] frame, input int nbits,
                           input int rel, output logic [7:0] rbits);
    rbits = '0;
    sclk = sel3;
    wait_clk(4);
    if (sel3) sen3 = 1'b0;
    else sen0 = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (sel3) sclk = 1'b0;
      sdi = frame[31-i];
      wait_clk(HALF);
      if (i >= 16 && i < 24) rbits[23-i] = sel3 ? sdo3 : sdo0;
      sclk = 1'b1;
      if (rel == 2 && i == nbits - 1) begin
        sen0 = 1'b1;
        sen3 = 1'b1;
      end
      wait_clk(HALF);
      if (!sel3) sclk = 1'b0;
    end
    if (rel == 1) begin
      wait_clk(HALF);
      sen0 = 1'b1;
      sen3 = 1'b1;
    end
    wait_clk(8);
  endtask

  initial begin
    logic [7:0] rb;
    int wb, rbase, fb, ob, w3b;

    wait_clk(5);
    rst = 1'b0;
    wait_clk(5);
    check("reset_sdo_oe", 32'(sdo_oe0), 32'h0);
    check("reset_sdo", 32'(sdo0), 32'h0);
    check("reset_wr_addr", 32'(wr_addr0), 32'h0);
    check("reset_rd_addr", 32'(rd_addr0), 32'h0);
    check("reset_wr_data", 32'(wr_data0), 32'h0);
    check("reset_sdo_oe3", 32'(sdo_oe3), 32'h0);
    $display("txn reset done");

    // Mode 0 write 0x123 <- 0xA5
    wb = wr_cnt0; ob = oe_cnt0; fb = ferr_cnt0;
    spi_frame(1'b0, 32'h0123A500, 24, 1, rb);
    $display("txn m0 write addr=123 data=a5 wr_addr=%0h wr_data=%0h", wr_addr0, wr_data0);
    check("t1_wr_count", 32'(wr_cnt0 - wb), 32'd1);
    check("t1_wr_addr", 32'(wr_addr0), 32'h123);
    check("t1_wr_data", 32'(wr_data0), 32'hA5);
    check("t1_oe_quiet", 32'(oe_cnt0 - ob), 32'd0);
    check("t1_no_err", 32'(ferr_cnt0 - fb), 32'd0);

    // Mode 0 read 0x045 -> 0x3C
    rd_data0 = 8'h3C;
    wb = wr_cnt0; rbase = rd_cnt0;
    spi_frame(1'b0, 32'h80450000, 24, 1, rb);
    $display("txn m0 read addr=045 rd_addr=%0h sdo_bits=%b", rd_addr0, rb);
`ifdef SPI_STREAM_EN
    check("t2_rd_count", 32'(rd_cnt0 - rbase), 32'd2);
    check("t2_rd_addr", 32'(rd_addr0), 32'h046);
`else
    check("t2_rd_count", 32'(rd_cnt0 - rbase), 32'd1);
    check("t2_rd_addr", 32'(rd_addr0), 32'h045);
`endif
    check("t2_sdo_bits", 32'(rb), 32'h3C);
    check("t2_no_write", 32'(wr_cnt0 - wb), 32'd0);
    check("t2_wr_addr_hold", 32'(wr_addr0), 32'h123);
    check("t2_oe_off", 32'(sdo_oe0), 32'h0);

    // Mode 3 write 0xFFF <- 0x01
    w3b = wr_cnt3;
    spi_frame(1'b1, 32'h0FFF0100, 24, 1, rb);
    $display("txn m3 write addr=fff data=01 wr_addr=%0h wr_data=%0h", wr_addr3, wr_data3);
    check("t3_wr_count", 32'(wr_cnt3 - w3b), 32'd1);
    check("t3_wr_addr", 32'(wr_addr3), 32'hFFF);
    check("t3_wr_data", 32'(wr_data3), 32'h01);

    // Abort after 10 bits, then a clean write 0x7E5 <- 0x5A
    wb = wr_cnt0; rbase = rd_cnt0; fb = ferr_cnt0;
    spi_frame(1'b0, 32'h8AAA5500, 10, 1, rb);
    $display("txn m0 abort after 10 bits frame_errs=%0d", ferr_cnt0 - fb);
    check("t4_frame_err", 32'(ferr_cnt0 - fb), 32'd1);
    check("t4_no_write", 32'(wr_cnt0 - wb), 32'd0);
    check("t4_no_read", 32'(rd_cnt0 - rbase), 32'd0);
    spi_frame(1'b0, 32'h07E55A00, 24, 1, rb);
    $display("txn m0 write addr=7e5 data=5a wr_addr=%0h wr_data=%0h", wr_addr0, wr_data0);
    check("t4_recover_count", 32'(wr_cnt0 - wb), 32'd1);
    check("t4_recover_addr", 32'(wr_addr0), 32'h7E5);
    check("t4_recover_data", 32'(wr_data0), 32'h5A);

    // Reset in the middle of a read at bit 17
    rbase = rd_cnt0;
    spi_frame(1'b0, 32'h80AB0000, 17, 0, rb);
    check("t5_rd_issued", 32'(rd_cnt0 - rbase), 32'd1);
    check("t5_oe_before_rst", 32'(sdo_oe0), 32'h1);
    rst = 1'b1;
    wait_clk(3);
    check("t5_oe_rst", 32'(sdo_oe0), 32'h0);
    check("t5_wr_addr_rst", 32'(wr_addr0), 32'h0);
    check("t5_rd_addr_rst", 32'(rd_addr0), 32'h0);
    check("t5_wr_data_rst", 32'(wr_data0), 32'h0);
    sen0 = 1'b1;
    sclk = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(5);
    $display("txn m0 reset during read");
    wb = wr_cnt0;
    spi_frame(1'b0, 32'h0456C300, 24, 1, rb);
    $display("txn m0 write addr=456 data=c3 wr_addr=%0h wr_data=%0h", wr_addr0, wr_data0);
    check("t5_after_count", 32'(wr_cnt0 - wb), 32'd1);
    check("t5_after_addr", 32'(wr_addr0), 32'h456);
    check("t5_after_data", 32'(wr_data0), 32'hC3);

    // SEN released on the same clock as the final sample edge
    wb = wr_cnt0; fb = ferr_cnt0;
    spi_frame(1'b0, 32'h03219600, 24, 2, rb);
    $display("txn m0 write addr=321 data=96 sen-on-last-edge wr_addr=%0h", wr_addr0);
    check("t7_count", 32'(wr_cnt0 - wb), 32'd1);
    check("t7_addr", 32'(wr_addr0), 32'h321);
    check("t7_data", 32'(wr_data0), 32'h96);
    check("t7_no_err", 32'(ferr_cnt0 - fb), 32'd0);

    // Two data words after one header at 0xFFF
    wb = wr_cnt0; fb = ferr_cnt0;
    spi_frame(1'b0, 32'h0FFF1122, 32, 1, rb);
    $display("txn m0 burst write addr=fff data=11,22 writes=%0d", wr_cnt0 - wb);
    check("t6_first_addr", 32'(wlog_addr[wb % 16]), 32'hFFF);
    check("t6_first_data", 32'(wlog_data[wb % 16]), 32'h11);
    check("t6_no_err", 32'(ferr_cnt0 - fb), 32'd0);
`ifdef SPI_STREAM_EN
    check("t6_count", 32'(wr_cnt0 - wb), 32'd2);
    check("t6_wrap_addr", 32'(wlog_addr[(wb + 1) % 16]), 32'h000);
    check("t6_wrap_data", 32'(wlog_data[(wb + 1) % 16]), 32'h22);
`else
    check("t6_count", 32'(wr_cnt0 - wb), 32'd1);
    check("t6_data_hold", 32'(wr_data0), 32'h11);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
